// File: rtl/chacha_blk_ctr_seq.sv
// Block-counter sequencer for the ChaCha20 keystream path: hands one counter
// value per keystream block to the core over valid/ready, per message.
module chacha_blk_ctr_seq #(
   parameter int unsigned      CTR_W      = 32,
   parameter logic [CTR_W-1:0] INIT_VAL   = CTR_W'(1),
   parameter int unsigned      LEN_W      = 16,
   parameter bit               ALLOW_WRAP = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             load,
   input  logic [CTR_W-1:0] load_val,
   input  logic             start,
   input  logic [LEN_W-1:0] num_blocks,
   input  logic             blk_ready,
   output logic             blk_valid,
   output logic [CTR_W-1:0] count,
   output logic [LEN_W-1:0] remaining,
   output logic             busy,
   output logic             done,
   output logic             wrapped,
   output logic             exhausted
);

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t state;
   logic   done_q;
   logic   wrapped_q;

   assign busy      = (state == ISSUE);
   assign blk_valid = busy & ~freeze;
   assign done      = done_q & ~freeze;
   assign wrapped   = wrapped_q & ~freeze;

   // NOTE: sequential state uses non-blocking assignments only, so every branch
   // below sees the pre-edge values of count/remaining/exhausted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= INIT_VAL;
         remaining <= '0;
         exhausted <= 1'b0;
         done_q    <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         // NOTE: pulses default low each cycle so they are exactly one cycle wide.
         done_q    <= 1'b0;
         wrapped_q <= 1'b0;
         if (!freeze) begin
            case (state)
               IDLE: begin
                  if (load) begin
                     count     <= load_val;
                     exhausted <= 1'b0;
                  end
                  // A same-cycle load clears exhaustion before the start is judged.
                  if (start && (!exhausted || load)) begin
                     if (num_blocks == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        remaining <= num_blocks;
                        state     <= ISSUE;
                     end
                  end
               end
               ISSUE: begin
                  if (blk_ready) begin
                     if ((count == '1) && !ALLOW_WRAP) begin
                        // Last usable counter went out; truncate rather than reuse keystream.
                        exhausted <= 1'b1;
                        remaining <= '0;
                        state     <= IDLE;
                        done_q    <= 1'b1;
                     end else begin
                        count <= count + CTR_W'(1);
                        if (count == '1) begin
                           wrapped_q <= 1'b1;
                        end
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                           state  <= IDLE;
                           done_q <= 1'b1;
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule
